ti_and_pipe: RTL
================

// Module: ti_and_pipe
// PURPOSE
//   Pipelined, WIDTH-bit bitwise AND over 3-share threshold-implementation (TI) operands.
//   Registered, non-complete output shares; optional fresh-randomness refresh stage.
//   Valid/ready flow control.
//   Building block for masked S-box and ALU datapaths; drops between share-domain producers and consumers.
// PARAMETERS
//   WIDTH    8  bits per share (bit-sliced, lanes independent)
//   REFRESH  1  1: add a refresh stage consuming rnd (latency 2); 0: no refresh (latency 1)
// PORTS
//   clk        in   1        clock, all state on rising edge
//   rst        in   1        asynchronous, active-high reset
//   in_valid   in   1        operand shares valid
//   in_ready   out  1        block accepts operands this cycle
//   a0,a1,a2   in   WIDTH    shares of A (A = a0^a1^a2)
//   b0,b1,b2   in   WIDTH    shares of B (B = b0^b1^b2)
//   rnd        in   2*WIDTH  fresh random bits {r1,r0}; ignored when REFRESH=0
//   out_valid  out  1        result shares valid
//   out_ready  in   1        downstream accepts result
//   q0,q1,q2   out  WIDTH    shares of Q = A & B
// BEHAVIOUR
// - Stage 1 (TI core), component functions, strictly non-complete:
//     f0 = (a1&b1)^(a1&b2)^(a2&b1)    no share index 0
//     f1 = (a2&b2)^(a0&b2)^(a2&b0)    no share index 1
//     f2 = (a0&b0)^(a0&b1)^(a1&b0)    no share index 2
//   Each fi is registered directly into its own stage-1 register (s1_q0..2).
//   No logic mixing fi outputs before the register.
// - Stage 2 (REFRESH=1 only), loads from stage 1:
//     q0 = s1_q0^r0, q1 = s1_q1^r1, q2 = s1_q2^r0^r1
//   rnd is sampled only on the cycle stage 2 loads; otherwise unused.
//   REFRESH=0: q0..q2 are the stage-1 registers.
// - Handshake, per stage k with valid bit vk:
//     transfer in  = in_valid & in_ready
//     transfer out = out_valid & out_ready
//     stage k may load when !vk, or when stage k+1 (or downstream) takes its data the same cycle
//     in_ready = stage-1 load condition (combinational from out_ready and valid bits; no path from in_valid)
//   Full throughput: one result per cycle while out_ready=1.
//   Latency: in transfer at cycle t -> out_valid at t+1 (REFRESH=0) or t+2 (REFRESH=1).
//   Stall (out_ready=0): q0..q2 and out_valid hold stable; no data dropped or duplicated.
//   Data stays in order; pipeline holds at most 1+REFRESH items.
//   With all stages full and out_ready=0, in_ready=0.
//   Simultaneous in and out transfer when full: pass-through with no bubble.
// - Data registers load only on their stage load; they never update with invalid data.
// - Reset (asynchronous assert, any time including mid-transfer): all valid bits 0, all share registers 0.
//   Resulting outputs: out_valid=0, q0=q1=q2=0. in_ready=1 while rst is low again; in-flight data discarded.
// - Width: all ops bitwise, no carries; lane i depends only on bit i of the inputs and of r0/r1.
// TESTING
// 1. REFRESH=0, WIDTH=8: a0..2=3C,5A,C3 (A=A5), b0..2=FF,11,E1 (B=0F), out_ready=1 -> out_valid 1 cycle later, q0^q1^q2=05.
// 2. REFRESH=1, same operands, rnd={r1,r0}={AA,55} -> out_valid at +2; q shares equal test-1 shares XOR (55,AA,FF); XOR still 05.
// 3. Non-completeness: toggle a0,b0 only, random A,B invariant per lane -> s1_q0 never changes; repeat for shares 1 and 2.
// 4. Back-to-back 100 random ops, out_ready=1 -> 100 results in order, each Q=A&B, in_ready constantly 1.
// 5. out_ready=0 for 5 cycles after 2 accepted ops (REFRESH=1) -> in_ready=0, outputs stable; release -> both results delivered, no loss.
// 6. Assert rst with pipeline full -> out_valid=0 and q=0 immediately (async); after release in_ready=1, no stale output appears.

Source files
------------

// File: rtl/ti_and_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ti_and_pipe
//  Purpose  : Pipelined bitwise AND over 3-share threshold-implementation
//             operands. The output shares are registered and non-complete.
//             An optional refresh stage re-masks the shares with fresh
//             randomness. Valid/ready flow control on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module ti_and_pipe #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned REFRESH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     a2,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     b1,
    input  logic [WIDTH-1:0]     b2,
    input  logic [2*WIDTH-1:0]   rnd,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     q0,
    output logic [WIDTH-1:0]     q1,
    output logic [WIDTH-1:0]     q2
);

    // Component functions. Each one omits one share index so that no single
    // function ever sees all shares of an operand. They go straight into
    // separate registers; nothing combines them before the flops.
    logic [WIDTH-1:0] w_f0;
    logic [WIDTH-1:0] w_f1;
    logic [WIDTH-1:0] w_f2;

    assign w_f0 = (a1 & b1) ^ (a1 & b2) ^ (a2 & b1);
    assign w_f1 = (a2 & b2) ^ (a0 & b2) ^ (a2 & b0);
    assign w_f2 = (a0 & b0) ^ (a0 & b1) ^ (a1 & b0);

    logic             r_s1_v;
    logic [WIDTH-1:0] r_s1_q0;
    logic [WIDTH-1:0] r_s1_q1;
    logic [WIDTH-1:0] r_s1_q2;

    // Stage 1 may load when empty or when its content leaves this cycle.
    logic w_s1_adv;

    assign in_ready = w_s1_adv;

    // Stage-1 valid bit: follows in_valid whenever the stage is allowed to load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_v <= in_valid;
        end
    end

    // Stage-1 share registers: written only on an accepted input transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_q0 <= '0;
            r_s1_q1 <= '0;
            r_s1_q2 <= '0;
        end else if (in_valid && w_s1_adv) begin
            r_s1_q0 <= w_f0;
            r_s1_q1 <= w_f1;
            r_s1_q2 <= w_f2;
        end
    end

    generate
        if (REFRESH != 0) begin : g_refresh
            logic             r_s2_v;
            logic [WIDTH-1:0] r_s2_q0;
            logic [WIDTH-1:0] r_s2_q1;
            logic [WIDTH-1:0] r_s2_q2;
            logic             w_s2_adv;
            logic [WIDTH-1:0] w_r0;
            logic [WIDTH-1:0] w_r1;

            assign w_r0     = rnd[WIDTH-1:0];
            assign w_r1     = rnd[2*WIDTH-1:WIDTH];
            assign w_s2_adv = !r_s2_v || out_ready;
            assign w_s1_adv = !r_s1_v || w_s2_adv;

            // Stage-2 valid bit: takes over the stage-1 valid bit when it may load.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s2_v <= 1'b0;
                end else if (w_s2_adv) begin
                    r_s2_v <= r_s1_v;
                end
            end

            // Stage-2 share registers: re-mask valid stage-1 shares; rnd used only here.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s2_q0 <= '0;
                    r_s2_q1 <= '0;
                    r_s2_q2 <= '0;
                end else if (w_s2_adv && r_s1_v) begin
                    r_s2_q0 <= r_s1_q0 ^ w_r0;
                    r_s2_q1 <= r_s1_q1 ^ w_r1;
                    r_s2_q2 <= r_s1_q2 ^ w_r0 ^ w_r1;
                end
            end

            assign out_valid = r_s2_v;
            assign q0        = r_s2_q0;
            assign q1        = r_s2_q1;
            assign q2        = r_s2_q2;
        end else begin : g_direct
            // Randomness input has no consumer in this configuration.
            logic w_unused_rnd;
            assign w_unused_rnd = ^rnd;

            assign w_s1_adv  = !r_s1_v || out_ready;
            assign out_valid = r_s1_v;
            assign q0        = r_s1_q0;
            assign q1        = r_s1_q1;
            assign q2        = r_s1_q2;
        end
    endgenerate

endmodule
`default_nettype wire
